// File: rtl/alut_mem_arbiter16_if.sv
// Request/response bundle between the two ALUT checkers and the memory arbiter.
// The master side drives the requests and the slave side returns the read data and status.
interface alut_mem_arbiter16_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 83,
    parameter int CNT_W  = 8
);
    logic              add_check_active16;
    logic [ADDR_W-1:0] mem_addr_add16;
    logic              mem_write_add16;
    logic [DATA_W-1:0] mem_write_data_add16;
    logic              age_check_active16;
    logic [ADDR_W-1:0] mem_addr_age16;
    logic              mem_write_age16;
    logic [DATA_W-1:0] mem_write_data_age16;
    logic [DATA_W-1:0] mem_read_data_add16;
    logic [DATA_W-1:0] mem_read_data_age16;
    logic              mem_init_done16;
    logic [CNT_W-1:0]  conflict_cnt16;
    logic              wr_ovfl16;

    modport master (
        output add_check_active16, mem_addr_add16, mem_write_add16, mem_write_data_add16,
        output age_check_active16, mem_addr_age16, mem_write_age16, mem_write_data_age16,
        input  mem_read_data_add16, mem_read_data_age16, mem_init_done16,
        input  conflict_cnt16, wr_ovfl16
    );

    modport slave (
        input  add_check_active16, mem_addr_add16, mem_write_add16, mem_write_data_add16,
        input  age_check_active16, mem_addr_age16, mem_write_age16, mem_write_data_age16,
        output mem_read_data_add16, mem_read_data_age16, mem_init_done16,
        output conflict_cnt16, wr_ovfl16
    );
endinterface

// File: rtl/alut_mem_arbiter16.sv
// ALUT storage array and two-port arbiter: address checker has priority, the age checker's
// colliding writes are parked in a one-entry buffer; a post-reset sweep clears the array.
module alut_mem_arbiter16 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 83,
    parameter int CNT_W  = 8
) (
    input logic                 pclk16,
    input logic                 p_reset16,
    alut_mem_arbiter16_if.slave bus
);
    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovfl_q, ovfl_d;
    logic [DATA_W-1:0] rd_add_q, rd_add_d;
    logic [DATA_W-1:0] rd_age_q, rd_age_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic add_wr, add_rd, age_wr, age_rd, age_defer, age_commit, flush;

    // Requests only count once the sweep has finished.
    assign add_wr     = done_q & bus.add_check_active16 & bus.mem_write_add16;
    assign add_rd     = done_q & bus.add_check_active16 & ~bus.mem_write_add16;
    assign age_wr     = done_q & bus.age_check_active16 & bus.mem_write_age16;
    assign age_rd     = done_q & bus.age_check_active16 & ~bus.mem_write_age16;
    assign age_defer  = age_wr & add_wr;
    assign age_commit = age_wr & ~add_wr;
    assign flush      = done_q & pend_v_q & ~add_wr & ~age_wr;

    // Freshest view of an address: this cycle's writes (address port first), then the buffer.
    function automatic logic [DATA_W-1:0] fwd(input logic [ADDR_W-1:0] raddr,
                                              input logic [DATA_W-1:0] arr_data);
        if (add_wr && bus.mem_addr_add16 == raddr)     return bus.mem_write_data_add16;
        else if (age_wr && bus.mem_addr_age16 == raddr) return bus.mem_write_data_age16;
        else if (pend_v_q && pend_addr_q == raddr)     return pend_data_q;
        else                                           return arr_data;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (!p_reset16) begin
            if (state_q == ST_INIT) begin
                mem_we = 1'b1;
            end else if (add_wr) begin
                mem_we    = 1'b1;
                mem_waddr = bus.mem_addr_add16;
                mem_wdata = bus.mem_write_data_add16;
            end else if (age_commit) begin
                mem_we    = 1'b1;
                mem_waddr = bus.mem_addr_age16;
                mem_wdata = bus.mem_write_data_age16;
            end else if (flush) begin
                mem_we    = 1'b1;
                mem_waddr = pend_addr_q;
                mem_wdata = pend_data_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        done_d      = done_q | (state_q == ST_RUN);
        cnt_d       = cnt_q;
        ovfl_d      = ovfl_q;
        rd_add_d    = rd_add_q;
        rd_age_d    = rd_age_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;

        if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == PTR_LAST) state_d = ST_RUN;
        end

        if (add_rd) rd_add_d = fwd(bus.mem_addr_add16, mem[bus.mem_addr_add16]);
        if (age_rd) rd_age_d = fwd(bus.mem_addr_age16, mem[bus.mem_addr_age16]);

        if (done_q && bus.add_check_active16 && bus.age_check_active16 && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        if (age_defer) begin
            // A different address still parked means that earlier age write is lost.
            if (pend_v_q && pend_addr_q != bus.mem_addr_age16) ovfl_d = 1'b1;
            pend_v_d    = 1'b1;
            pend_addr_d = bus.mem_addr_age16;
            pend_data_d = bus.mem_write_data_age16;
        end else if (flush) begin
            pend_v_d = 1'b0;
        end
    end

    always_ff @(posedge pclk16) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (p_reset16) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            ovfl_q      <= 1'b0;
            rd_add_q    <= '0;
            rd_age_q    <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            ovfl_q      <= ovfl_d;
            rd_add_q    <= rd_add_d;
            rd_age_q    <= rd_age_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    // NOTE: the array has no reset branch so it maps onto RAM; the INIT sweep clears it instead.
    always_ff @(posedge pclk16) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.mem_read_data_add16 = rd_add_q;
    assign bus.mem_read_data_age16 = rd_age_q;
    assign bus.mem_init_done16     = done_q;
    assign bus.conflict_cnt16      = cnt_q;
    assign bus.wr_ovfl16           = ovfl_q;
endmodule
